// File: rtl/out_accum_defs.sv
// Shared constants for the output accumulator: FSM encoding and default geometry.
package out_accum_defs;
  localparam int COL_DEF     = 8;
  localparam int PSUM_BW_DEF = 16;
  localparam int DEPTH_DEF   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/psum_sat_add.sv
// One lane of the accumulator: signed add clamped to the psum_bw range.
module psum_sat_add #(
  parameter int psum_bw = 16
) (
  input  logic signed [psum_bw-1:0] a,
  input  logic signed [psum_bw-1:0] b,
  output logic signed [psum_bw-1:0] y
);
  function automatic logic signed [psum_bw-1:0] sat(input logic signed [psum_bw:0] s);
    // The two top bits disagree only when the sum left the representable range.
    if (s[psum_bw] != s[psum_bw-1])
      return s[psum_bw] ? $signed({1'b1, {(psum_bw-1){1'b0}}})
                        : $signed({1'b0, {(psum_bw-1){1'b1}}});
    return $signed(s[psum_bw-1:0]);
  endfunction

  logic signed [psum_bw:0] sum;

  assign sum = a + b;
  assign y   = sat(sum);
endmodule

// File: rtl/out_accum.sv
// Sums num_tiles K-tiles of depth rows from the core into a local buffer,
// then drains the rows with a valid/ready handshake and optional ReLU.
module out_accum
  import out_accum_defs::*;
#(
  parameter int col     = COL_DEF,
  parameter int psum_bw = PSUM_BW_DEF,
  parameter int depth   = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             num_tiles,
  input  logic                   relu_en,
  input  logic                   in_valid,
  input  logic [col*psum_bw-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [col*psum_bw-1:0] out_data,
  output logic                   busy,
  output logic                   done,
  output logic                   drop_err
);
  localparam int W  = col * psum_bw;
  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [AW-1:0] LAST = AW'(depth - 1);

  state_t state, state_nxt;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [3:0]    tile_cnt, tiles_m1;
  logic          relu_q, done_q, drop_q;

  logic [W-1:0]  mem [depth];
  logic [W-1:0]  acc_word, sum_word, wr_word, rd_word;

  logic accept, wrap, last_wrap, drain_hs, drain_last;

  assign accept     = (state == ST_ACCUM) && in_valid;
  assign wrap       = accept && (wr_ptr == LAST);
  assign last_wrap  = wrap && (tile_cnt == tiles_m1);
  assign drain_hs   = (state == ST_DRAIN) && out_ready;
  assign drain_last = drain_hs && (rd_ptr == LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start)      state_nxt = ST_ACCUM;
      ST_ACCUM: if (last_wrap)  state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_last) state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tile_cnt <= '0;
      tiles_m1 <= '0;
      relu_q   <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      done_q <= drain_last;
      if (state == ST_IDLE && start) begin
        wr_ptr   <= '0;
        tile_cnt <= '0;
        tiles_m1 <= (num_tiles == 4'd0) ? 4'd0 : num_tiles - 4'd1;
        relu_q   <= relu_en;
        drop_q   <= 1'b0;
      end
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (wrap)   tile_cnt <= tile_cnt + 4'd1;
      if (last_wrap) rd_ptr <= '0;
      else if (drain_hs) rd_ptr <= rd_ptr + 1'b1;
      // Words arriving while not accumulating are dropped but remembered.
      if (in_valid && state != ST_ACCUM) drop_q <= 1'b1;
    end
  end

  // Accumulate stage: read-modify-write of one row per accepted word
  assign acc_word = mem[wr_ptr];
  assign wr_word  = (tile_cnt == 4'd0) ? in_data : sum_word;

  for (genvar g = 0; g < col; g++) begin : g_lane
    psum_sat_add #(.psum_bw(psum_bw)) u_add (
      .a(acc_word[g*psum_bw +: psum_bw]),
      .b(in_data[g*psum_bw +: psum_bw]),
      .y(sum_word[g*psum_bw +: psum_bw])
    );
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= wr_word;
  end

  // Drain stage: buffer is frozen here, so the read word holds under backpressure
  assign rd_word = mem[rd_ptr];

  always_comb begin
    out_data = rd_word;
    if (relu_q) begin
      for (int l = 0; l < col; l++)
        if (rd_word[l*psum_bw + psum_bw - 1]) out_data[l*psum_bw +: psum_bw] = '0;
    end
  end

  assign out_valid = (state == ST_DRAIN);
  assign busy      = (state != ST_IDLE);
  assign done      = done_q;
  assign drop_err  = drop_q;
endmodule

// File: tb/tb_out_accum.sv
// Randomized bench for out_accum against a row/tile arithmetic model.
module tb_out_accum;
  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int DEP = 8;
  localparam int W   = COL * BW;

  logic         clk = 1'b0;
  logic         reset, start, relu_en, in_valid, out_ready;
  logic [3:0]   num_tiles;
  logic [W-1:0] in_data, out_data;
  logic         out_valid, busy, done, drop_err;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] stim [16][DEP];
  logic [W-1:0] drained [DEP];
  int           got;
  int           unstable;

  out_accum #(.col(COL), .psum_bw(BW), .depth(DEP)) dut (
    .clk(clk), .reset(reset), .start(start), .num_tiles(num_tiles), .relu_en(relu_en),
    .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int l = 0; l < COL; l++) w[l*BW +: BW] = 16'($urandom);
    return w;
  endfunction

  // Row r after summing ntiles tiles, each partial sum clamped to 16-bit signed.
  function automatic logic [W-1:0] model_row(int r, int ntiles, bit relu);
    logic [W-1:0] w;
    int acc, v, eff;
    eff = (ntiles == 0) ? 1 : ntiles;
    for (int l = 0; l < COL; l++) begin
      acc = 0;
      for (int t = 0; t < eff; t++) begin
        v = int'($signed(stim[t][r][l*BW +: BW]));
        acc = (t == 0) ? v : acc + v;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
      end
      if (relu && acc < 0) acc = 0;
      w[l*BW +: BW] = 16'(acc);
    end
    return w;
  endfunction

  task automatic fill_random(int ntiles);
    for (int t = 0; t < 16; t++)
      for (int r = 0; r < DEP; r++) stim[t][r] = rand_word();
  endtask

  task automatic start_job(int nt, bit relu);
    start = 1'b1; num_tiles = 4'(nt); relu_en = relu;
    @(negedge clk);
    start = 1'b0; num_tiles = 4'($urandom); relu_en = ~relu;
  endtask

  task automatic feed_job(int nt, bit inject_start);
    int eff;
    eff = (nt == 0) ? 1 : nt;
    for (int t = 0; t < eff; t++)
      for (int r = 0; r < DEP; r++) begin
        in_valid = 1'b1; in_data = stim[t][r];
        start = inject_start && t == 0 && r == 2;
        @(negedge clk);
      end
    in_valid = 1'b0; start = 1'b0; in_data = rand_word();
  endtask

  task automatic drain_job(bit bp);
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] held;
    bit stalled;
    int cyc;
    got = 0; unstable = 0; cyc = 0; stalled = 0; held = '0;
    while (got < DEP && cyc < 200) begin
      out_ready = bp ? pat[cyc % 4] : 1'b1;
      if (out_valid) begin
        if (stalled && out_data !== held) unstable++;
        if (out_ready) begin drained[got] = out_data; got++; stalled = 0; end
        else begin held = out_data; stalled = 1; end
      end
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL reset_drop_err got=%b exp=0", drop_err); end
  endtask

  task automatic test_single_tile();
    fill_random(1);
    for (int r = 0; r < DEP; r++) stim[0][r][BW-1:0] = 16'(r + 1);
    start_job(1, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    feed_job(1, 0);
    drain_job(0);
    checks++; if (got !== DEP) begin errors++; $display("FAIL single_count got=%0d exp=%0d", got, DEP); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done got=%b exp=1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    for (int r = 0; r < DEP; r++) begin
      checks++;
      if (drained[r][BW-1:0] !== 16'(r + 1) || drained[r] !== model_row(r, 1, 0)) begin
        errors++; $display("FAIL single_row%0d got=%h exp=%h", r, drained[r], model_row(r, 1, 0));
      end
    end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_three_tiles();
    for (int t = 0; t < 3; t++)
      for (int r = 0; r < DEP; r++) stim[t][r] = {COL{16'd5}};
    start_job(3, 0);
    feed_job(3, 0);
    drain_job(0);
    checks++; if (got !== DEP) begin errors++; $display("FAIL three_count got=%0d exp=%0d", got, DEP); end
    for (int r = 0; r < DEP; r++) begin
      checks++;
      if (drained[r] !== {COL{16'd15}}) begin
        errors++; $display("FAIL three_row%0d got=%h exp=%h", r, drained[r], {COL{16'd15}});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_sat_relu();
    fill_random(2);
    for (int t = 0; t < 2; t++)
      for (int r = 0; r < DEP; r++) begin
        stim[t][r][BW-1:0]  = 16'h7000;
        stim[t][r][2*BW-1:BW] = 16'h9000;
      end
    start_job(2, 0);
    feed_job(2, 0);
    drain_job(0);
    checks++; if (drained[0][BW-1:0] !== 16'h7FFF) begin errors++; $display("FAIL sat_pos got=%h exp=7fff", drained[0][BW-1:0]); end
    checks++; if (drained[5][2*BW-1:BW] !== 16'h8000) begin errors++; $display("FAIL sat_neg got=%h exp=8000", drained[5][2*BW-1:BW]); end
    for (int r = 0; r < DEP; r++) begin
      checks++;
      if (drained[r] !== model_row(r, 2, 0)) begin errors++; $display("FAIL sat_row%0d got=%h exp=%h", r, drained[r], model_row(r, 2, 0)); end
    end
    @(negedge clk);
    fill_random(1);
    for (int r = 0; r < DEP; r++) begin
      stim[0][r][BW-1:0] = 16'hFFFD;
      stim[0][r][2*BW-1:BW] = 16'd7;
    end
    start_job(1, 1);
    feed_job(1, 0);
    drain_job(0);
    checks++; if (drained[3][BW-1:0] !== 16'h0000) begin errors++; $display("FAIL relu_neg got=%h exp=0000", drained[3][BW-1:0]); end
    checks++; if (drained[3][2*BW-1:BW] !== 16'd7) begin errors++; $display("FAIL relu_pos got=%h exp=0007", drained[3][2*BW-1:BW]); end
    for (int r = 0; r < DEP; r++) begin
      checks++;
      if (drained[r] !== model_row(r, 1, 1)) begin errors++; $display("FAIL relu_row%0d got=%h exp=%h", r, drained[r], model_row(r, 1, 1)); end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    fill_random(2);
    start_job(2, 0);
    feed_job(2, 0);
    drain_job(1);
    checks++; if (got !== DEP) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", got, DEP); end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL bp_stable got=%0d changes exp=0", unstable); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done got=%b exp=1", done); end
    for (int r = 0; r < DEP; r++) begin
      checks++;
      if (drained[r] !== model_row(r, 2, 0)) begin errors++; $display("FAIL bp_row%0d got=%h exp=%h", r, drained[r], model_row(r, 2, 0)); end
    end
    @(negedge clk);
  endtask

  task automatic test_random_tiles();
    int nt;
    for (int it = 0; it < 4; it++) begin
      nt = (it == 0) ? 0 : $urandom_range(1, 4);
      fill_random(nt);
      start_job(nt, it[0]);
      feed_job(nt, it == 1);
      drain_job(it[1]);
      checks++; if (got !== DEP) begin errors++; $display("FAIL rand%0d_count got=%0d exp=%0d", it, got, DEP); end
      for (int r = 0; r < DEP; r++) begin
        checks++;
        if (drained[r] !== model_row(r, nt, it[0])) begin
          errors++; $display("FAIL rand%0d_row%0d got=%h exp=%h", it, r, drained[r], model_row(r, nt, it[0]));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_errors();
    fill_random(1);
    start_job(1, 0);
    feed_job(1, 0);
    in_valid = 1'b1; in_data = rand_word();
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL err_drain_set got=%b exp=1", drop_err); end
    drain_job(0);
    for (int r = 0; r < DEP; r++) begin
      checks++;
      if (drained[r] !== model_row(r, 1, 0)) begin errors++; $display("FAIL err_row%0d got=%h exp=%h", r, drained[r], model_row(r, 1, 0)); end
    end
    @(negedge clk);
    checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", drop_err); end
    fill_random(1);
    start_job(1, 0);
    checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", drop_err); end
    feed_job(1, 0);
    drain_job(0);
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL err_idle_set got=%b exp=1", drop_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    fill_random(1);
    start_job(2, 0);
    for (int r = 0; r < 3; r++) begin
      in_valid = 1'b1; in_data = rand_word();
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_pre got=%b exp=1", busy); end
    reset = 1'b1; start = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got=%b exp=0", out_valid); end
    checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL rmid_drop_err got=%b exp=0", drop_err); end
    start_job(1, 0);
    feed_job(1, 0);
    drain_job(0);
    checks++; if (got !== DEP) begin errors++; $display("FAIL rmid_count got=%0d exp=%0d", got, DEP); end
    for (int r = 0; r < DEP; r++) begin
      checks++;
      if (drained[r] !== model_row(r, 1, 0)) begin errors++; $display("FAIL rmid_row%0d got=%h exp=%h", r, drained[r], model_row(r, 1, 0)); end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_tiles = '0; relu_en = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_tile();
    test_three_tiles();
    test_sat_relu();
    test_backpressure();
    test_random_tiles();
    test_errors();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/out_accum.md
OUT_ACCUM -- requirements
Module: out_accum

Interface
REQ-001 SHALL have parameter col, default 8: PE columns, i.e. lanes per word.
REQ-002 SHALL have parameter psum_bw, default 16: signed partial-sum width per lane.
REQ-003 SHALL have parameter depth, default 8: output rows held per tile (power of 2).
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: one-cycle command to begin a new accumulation job.
REQ-007 SHALL have port num_tiles, input, 4: number of K-tiles to sum, sampled on start.
REQ-008 SHALL have port relu_en, input, 1: apply ReLU at drain, sampled on start.
REQ-009 SHALL have port in_valid, input, 1: driven from core ofifo_valid.
REQ-010 SHALL have port in_data, input, col*psum_bw: driven from core sfp_out; lane i = bits [i*psum_bw +: psum_bw].
REQ-011 SHALL have port out_valid, output, 1: drain word available.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts word.
REQ-013 SHALL have port out_data, output, col*psum_bw: drain word.
REQ-014 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-015 SHALL have port done, output, 1: one-cycle pulse after last drain handshake.
REQ-016 SHALL have port drop_err, output, 1: sticky flag for in_valid outside ACCUM.

Function
REQ-017 SHALL implement FSM with states IDLE, ACCUM, DRAIN.
REQ-018 IDLE->ACCUM SHALL occur on start; latch num_tiles (0 treated as 1) and relu_en; clear wr_ptr and tile_cnt.
REQ-019 start outside IDLE SHALL be ignored.
REQ-020 In ACCUM, each in_valid cycle SHALL write buf[wr_ptr] = in_data when tile_cnt==0, else buf[wr_ptr] + in_data per lane.
REQ-021 Lane addition SHALL be signed and saturate to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
REQ-022 wr_ptr SHALL increment per accepted word and wrap depth-1->0, incrementing tile_cnt on wrap.
REQ-023 The wrap of the last tile (tile_cnt == num_tiles-1) SHALL move the FSM to DRAIN with rd_ptr=0 on the next cycle.
REQ-024 Write latency SHALL be one cycle: a word written at edge N is readable for accumulation at edge N+1, so back-to-back in_valid is supported.
REQ-025 In DRAIN, out_valid SHALL be 1 and out_data SHALL be buf[rd_ptr], with negative lanes forced to 0 when relu_en is latched.
REQ-026 out_data SHALL hold stable while out_valid && !out_ready.
REQ-027 rd_ptr SHALL advance on each out_valid && out_ready.
REQ-028 The handshake at rd_ptr==depth-1 SHALL return the FSM to IDLE and assert done for exactly the following cycle.
REQ-029 in_valid in IDLE or DRAIN SHALL be discarded without changing buf and SHALL set drop_err.
REQ-030 drop_err SHALL clear only on reset or on an accepted start.
REQ-031 out_valid SHALL be 0 outside DRAIN.

Reset
REQ-032 reset SHALL force the FSM to IDLE and clear wr_ptr, rd_ptr, tile_cnt, out_valid, busy, done and drop_err, including mid-ACCUM or mid-DRAIN.
REQ-033 buf contents SHALL NOT require reset; the first tile overwrites them.
REQ-034 reset SHALL take priority over start and in_valid in the same cycle.

Structure
REQ-035 State encodings and the default col, psum_bw and depth values SHALL live in a shared constants include, out_accum_defs.
REQ-036 Per-lane saturating adder SHALL be a sub-module psum_sat_add, instantiated col times via generate.

Verification
REQ-037 Single tile: start with num_tiles=1, relu_en=0, feed 8 words with lane0 = 1..8 -> drain lane0 = 1..8, then done pulse, busy=0.
REQ-038 Three tiles: num_tiles=3, every lane = 5 in every word -> all drained lanes = 15.
REQ-039 Saturation and ReLU: num_tiles=2, lane = 0x7000 twice -> 0x7FFF; lane = -3 with relu_en=1 -> 0x0000.
REQ-040 Backpressure: out_ready toggles 1,0,0,1 -> each word appears once, stable while stalled; done follows the 8th handshake.
REQ-041 Errors: in_valid during DRAIN -> drop_err=1 and drained data unchanged; next start clears drop_err.
REQ-042 Reset mid-ACCUM after 3 words -> IDLE, out_valid=0; a fresh single-tile job drains only new data.
